// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural Hi/Lo registers.
// Handles MULT, MULTU, DIV and DIVU one bit per clock. Results reach Hi/Lo only
// on the commit edge. MTHI and MTLO write Hi/Lo directly from IDLE.
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst     asynchronous reset, active-high
//   i_start   issue request, sampled on the rising edge
//   i_op      0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6 and 7 are no-ops
//   i_a       rs operand (multiplicand / dividend / MTHI-MTLO source)
//   i_b       rt operand (multiplier / divisor)
//   i_cancel  flush; aborts the operation in flight and drops a same-cycle start
//   i_rd_req  EX holds MFHI or MFLO this cycle
//   o_busy    an operation is in flight
//   o_done    one-cycle pulse after an arithmetic Hi/Lo commit
//   o_stall   to hazard unit; holds PC and IF/ID
//   o_hi      committed Hi register
//   o_lo      committed Lo register

module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cancel,
    input  logic             i_rd_req,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stall,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             r_state;
    state_e             w_state_next;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_is_div;
    logic               r_neg_res;  // negate product / quotient at commit
    logic               r_neg_rem;  // negate remainder at commit (signed dividend < 0)
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand magnitude, or divisor magnitude
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] r_acc;

    logic               w_busy;
    logic               w_signed;
    logic               w_b_zero;
    logic               w_neg_res;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand conditioning at issue
    assign w_signed  = ~i_op[0];
    assign w_b_zero  = (i_b == '0);
    assign w_abs_a   = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_abs_b   = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    // Divide by zero keeps the all-ones quotient un-negated; the remainder path
    // already reproduces the original dividend once its sign is restored.
    assign w_neg_res = w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]) & ~(i_op[1] & w_b_zero);

    // One iteration of shift-add multiply
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // One iteration of restoring divide
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    // When the subtraction is taken the result is below the divisor, so WIDTH bits suffice.
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;

    assign w_acc_step = r_is_div
        ? {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_div_ge}
        : {w_mul_sum, r_acc[WIDTH-1:1]};

    // Sign fix-up applied only at commit
    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; cancel wins over every transition out of RUN/FIX
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start && !i_cancel && !i_op[2]) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (i_cancel) begin
                    w_state_next = StIdle;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_next = StFix;
                end
            end
            StFix: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        w_busy  = (r_state != StIdle);
        o_busy  = w_busy;
        o_stall = w_busy & (i_rd_req | i_start);
    end

    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

    // Datapath and architectural registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start && !i_cancel) begin
                        case (i_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_is_div  <= i_op[1];
                                r_neg_res <= w_neg_res;
                                r_neg_rem <= w_signed & i_a[WIDTH-1];
                                r_cnt     <= '0;
                                if (i_op[1]) begin
                                    r_opnd <= w_abs_b;
                                    r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                                end else begin
                                    r_opnd <= w_abs_a;
                                    r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                                end
                            end
                            3'd4:    r_hi <= i_a;
                            3'd5:    r_lo <= i_a;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    if (!i_cancel) begin
                        r_acc <= w_acc_step;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StFix: begin
                    if (!i_cancel) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, cancel/stall/reset
// scenarios and a randomized op stream checked against an arithmetic model.

module tb_muldiv_unit;

    localparam int W = 32;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        rd_req = 1'b0;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    // 8-bit instance
    logic        rst8 = 1'b1;
    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, stall8;
    logic [7:0]  hi8, lo8;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .i_cancel (cancel),
        .i_rd_req (rd_req),
        .o_busy   (busy),
        .o_done   (done),
        .o_stall  (stall),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    muldiv_unit #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .i_clk    (clk),
        .i_rst    (rst8),
        .i_start  (start8),
        .i_op     (op8),
        .i_a      (a8),
        .i_b      (b8),
        .i_cancel (1'b0),
        .i_rd_req (1'b0),
        .o_busy   (busy8),
        .o_done   (done8),
        .o_stall  (stall8),
        .o_hi     (hi8),
        .o_lo     (lo8)
    );

    // Architectural effect of one op on Hi/Lo, from plain integer arithmetic
    task automatic model_apply(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        case (mop)
            3'd0: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd1: begin
                p = {32'b0, ma} * {32'b0, mb};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                if (mb == 0) begin
                    m_hi = ma;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = 32'(q);
                    m_hi = 32'(r);
                end
            end
            3'd3: begin
                if (mb == 0) begin
                    m_hi = ma;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    m_lo = ma / mb;
                    m_hi = ma % mb;
                end
            end
            3'd4: m_hi = ma;
            3'd5: m_lo = ma;
            default: ;
        endcase
    endtask

    // Issue one op from IDLE at a negedge and follow it to completion
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string name);
        int          nbusy;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        model_apply(o, x, y);
        if (o <= 3'd3) begin
            nbusy = 0;
            while (busy === 1'b1 && nbusy < 100) begin
                checks++;
                if (hi !== old_hi || lo !== old_lo) begin
                    errors++;
                    $display("FAIL %s partial: hi=%h lo=%h, expected hi=%h lo=%h",
                             name, hi, lo, old_hi, old_lo);
                end
                nbusy++;
                @(negedge clk);
            end
            checks++;
            if (nbusy != W + 1) begin
                errors++;
                $display("FAIL %s busy_len: got %0d cycles, expected %0d", name, nbusy, W + 1);
            end
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL %s done: got %b, expected 1", name, done);
            end
        end else begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_op: busy=%b done=%b, expected 0 0", name, busy, done);
            end
        end
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_len: done=%b, expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, expected all 0",
                     hi, lo, busy, done, stall);
        end
    endtask

    task automatic test_directed();
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max_const: hi=%h lo=%h, expected fffffffe 00000001", hi, lo);
        end
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_neg_const: hi=%h lo=%h, expected ffffffff ffffffeb", hi, lo);
        end
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_neg_const: hi=%h lo=%h, expected ffffffff fffffffd", hi, lo);
        end
        run_op(3'd3, 32'd100, 32'd0, "divu_zero");
        checks++;
        if (hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divu_zero_const: hi=%h lo=%h, expected 00000064 ffffffff", hi, lo);
        end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        checks++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_ovf_const: hi=%h lo=%h, expected 00000000 80000000", hi, lo);
        end
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0, "div_neg_zero");
        checks++;
        if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_neg_zero_const: hi=%h lo=%h, expected fffffff9 ffffffff", hi, lo);
        end
    endtask

    task automatic test_cancel();
        // Cancel during RUN
        start = 1'b1;
        op = 3'd0;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL cancel_run: busy=%b done=%b hi=%h lo=%h, expected 0 0 %h %h",
                     busy, done, hi, lo, m_hi, m_lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL cancel_run_done: done=%b, expected 0", done);
        end
        // MTLO straight after
        start = 1'b1;
        op = 3'd5;
        a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        m_lo = 32'h1234;
        checks++;
        if (lo !== 32'h1234 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: lo=%h busy=%b, expected 00001234 0", lo, busy);
        end
        // Cancel in the FIX cycle suppresses the commit
        start = 1'b1;
        op = 3'd3;
        a = $urandom;
        b = $urandom_range(1, 1000);
        @(negedge clk);
        start = 1'b0;
        repeat (W) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_fix_pre: busy=%b, expected 1", busy);
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL cancel_fix: busy=%b done=%b hi=%h lo=%h, expected 0 0 %h %h",
                     busy, done, hi, lo, m_hi, m_lo);
        end
        // Cancel in IDLE drops a same-cycle start
        start = 1'b1;
        cancel = 1'b1;
        op = 3'd4;
        a = 32'hA5A5_0001;
        @(negedge clk);
        checks++;
        if (hi !== m_hi || busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle_mthi: hi=%h busy=%b, expected %h 0", hi, busy, m_hi);
        end
        op = 3'd0;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle_mult: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_stall();
        int n;
        start = 1'b1;
        op = 3'd3;
        a = $urandom;
        b = $urandom_range(1, 1000);
        model_apply(3'd3, a, b);
        @(negedge clk);
        // Hold a second request (MTHI) plus rd_req for the whole busy window
        op = 3'd4;
        a = 32'hDEAD_BEEF;
        rd_req = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL stall_busy: cycle %0d stall=%b, expected 1", n, stall);
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != W + 1 || stall !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: busy_len=%0d stall=%b done=%b, expected %0d 0 1",
                     n, stall, done, W + 1);
        end
        start = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_second_start: hi=%h lo=%h busy=%b, expected %h %h 0",
                     hi, lo, busy, m_hi, m_lo);
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       x = 32'h8000_0000;
                1:       x = 32'($urandom_range(0, 20));
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       y = 32'h0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            run_op(o, x, y, "random");
        end
    endtask

    task automatic test_width8();
        int n;
        start8 = 1'b1;
        op8 = 3'd0;
        a8 = 8'h80;
        b8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (busy8 === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 9 || {hi8, lo8} !== 16'h4000 || done8 !== 1'b1) begin
            errors++;
            $display("FAIL w8_mult: busy_len=%0d hilo=%h done=%b, expected 9 4000 1",
                     n, {hi8, lo8}, done8);
        end
        // Asynchronous reset in the middle of RUN
        start8 = 1'b1;
        op8 = 3'd1;
        a8 = 8'hFF;
        b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL w8_pre_reset: busy=%b, expected 1", busy8);
        end
        #2 rst8 = 1'b1;
        #1;
        checks++;
        if (hi8 !== 8'h0 || lo8 !== 8'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL w8_async_reset: hi=%h lo=%h busy=%b done=%b, expected 0 0 0 0",
                     hi8, lo8, busy8, done8);
        end
        @(negedge clk);
        rst8 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || hi8 !== 8'h0 || lo8 !== 8'h0) begin
            errors++;
            $display("FAIL w8_post_reset: busy=%b hi=%h lo=%h, expected 0 0 0", busy8, hi8, lo8);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_cancel();
        test_stall();
        test_random();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected completion before 500000");
        $fatal(1, "timeout");
    end

endmodule
